fp_result_fifo: RTL and testbench
=================================

Name: fp_result_fifo

Overview:
- Downstream capture stage for the combinational FP32 adder (AddOp).
- Registers each adder result together with its under_overflow flag into a show-ahead FIFO.
- Classifies each result (zero/inf/NaN/denormal) at write time and keeps a saturating count of under/overflow events.
- Feeds the result sink / file-dump logic through a valid/ready handshake, so the combinational adder can be driven at full rate without losing results.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- CNT_W, 16, width of the under/overflow event counter.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  adder result present this cycle.
- in_data  input  32  FP32 result from the adder (its out port).
- in_uof  input  1  under_overflow flag from the adder.
- in_ready  output  1  FIFO can accept; equals !full.
- out_valid  output  1  head entry available; equals !empty.
- out_ready  input  1  consumer takes the head entry.
- out_data  output  32  head FP32 word.
- out_flags  output  5  head flags {uof, nan, inf, denorm, zero}.
- count  output  $clog2(DEPTH)+1  current occupancy.
- uof_cnt  output  CNT_W  accepted entries with in_uof=1, saturating.
- clr_cnt  input  1  synchronous clear of uof_cnt.
- drop_err  output  1  sticky; set when in_valid=1 while in_ready=0.

Behaviour:
- Reset (rst_n=0 at a rising edge) sets:
  - rd_ptr = wr_ptr = 0, count = 0.
  - out_valid = 0, in_ready = 1, uof_cnt = 0, drop_err = 0.
  - out_data and out_flags read as 0 while empty.
- Reset mid-operation discards all stored entries. Memory contents need not be cleared.
- Push occurs on a rising edge when in_valid && in_ready.
  - Stored entry: in_data, plus flags computed from in_data, plus in_uof.
- Flag classification: e = in_data[30:23], m = in_data[22:0].
  - zero: e=0, m=0.
  - denorm: e=0, m!=0.
  - inf: e=8'hFF, m=0.
  - nan: e=8'hFF, m!=0.
  - Sign is ignored. At most one of the four class bits is set.
- Pop occurs on a rising edge when out_valid && out_ready.
- Show-ahead read: out_data and out_flags always reflect the head entry, driven combinationally from the storage array indexed by rd_ptr.
- Latency: a word pushed into an empty FIFO at edge N gives out_valid=1 after edge N. There is no bypass in the same cycle.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Full (count=DEPTH): in_ready=0 and any push is refused. A pop in the same cycle does not enable a push; the push is accepted on the next cycle.
- Refused in_valid sets drop_err=1. It stays set until reset; clr_cnt does not clear it.
- Empty: out_valid=0 and out_ready is ignored. Count never underflows.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. Full and empty are derived from count.
- uof_cnt:
  - Increments by 1 on each accepted push with in_uof=1.
  - Saturates at 2^CNT_W-1.
  - clr_cnt alone sets it to 0.
  - clr_cnt together with a counted push in the same cycle sets it to 1.
- All outputs except out_data, out_flags, in_ready and out_valid come directly from registers.

Test Plan:
- Reset then push 3F800000 (uof=0), then 7F800000 (uof=1) on back-to-back cycles with out_ready=0 -> count=2; head out_data=3F800000, out_flags=00000; uof_cnt=1.
- Pop once from the previous state -> out_data=7F800000, out_flags=10100, count=1. Push 7FC00001 -> flags 01000. Push 00000001 -> flags 00010. Push 80000000 -> flags 00001.
- Push 9 consecutive words with DEPTH=8 and out_ready=0 -> in_ready=0 after the 8th push; the 9th word is not stored and drop_err=1. Drain all 8 -> words are in order 1..8, then out_valid=0.
- Steady stream with in_valid=out_ready=1 for 20 cycles, with pointers wrapping twice -> count stays 1, output sequence equals the input sequence delayed one cycle, drop_err=0.
- Force uof_cnt to FFFE, then push 3 uof=1 words -> uof_cnt=FFFF. Then assert clr_cnt together with a uof=1 push -> uof_cnt=0001.
- Fill with 5 entries and assert rst_n=0 for one edge -> count=0, out_valid=0, in_ready=1, uof_cnt=0, drop_err=0. The next push appears at the head one cycle later.

Source files
------------

// File: rtl/fp_result_fifo.sv
// ---------------------------------------------------------------------------
// FpResultFifo (module fp_result_fifo)
//
// Capture stage behind the combinational FP32 adder. Every accepted adder
// result is stored with its under/overflow flag and a four-way class
// (zero / denormal / inf / NaN) in a show-ahead FIFO. The consumer sees the
// head entry combinationally and pops it with a valid/ready handshake.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : synchronous reset, active low
//   in_valid   : adder result present this cycle
//   in_data    : FP32 adder result
//   in_uof     : adder under/overflow flag
//   in_ready   : FIFO can accept (not full)
//   out_valid  : head entry available (not empty)
//   out_ready  : consumer takes the head entry
//   out_data   : head FP32 word (0 while empty)
//   out_flags  : head flags {uof, nan, inf, denorm, zero} (0 while empty)
//   count      : current occupancy
//   uof_cnt    : saturating count of accepted entries with in_uof=1
//   clr_cnt    : synchronous clear of uof_cnt
//   drop_err   : sticky, set when a result arrives while the FIFO is full
// ---------------------------------------------------------------------------
module fp_result_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  input  logic                     in_uof,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         uof_cnt,
  input  logic                     clr_cnt,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 37;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_uofCnt;
  logic             r_dropErr;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_exp;
  logic [22:0]      w_man;
  logic [4:0]       w_flags;
  logic [EW-1:0]    w_head;

  // Full/empty come from the occupancy count, so the pointers can simply
  // wrap modulo DEPTH without an extra wrap bit.
  always_comb begin
    w_full  = (r_count == CW'(DEPTH));
    w_empty = (r_count == '0);
    w_push  = in_valid && !w_full;
    w_pop   = out_ready && !w_empty;
  end

  // Classify the incoming word; sign is ignored and the four class bits are
  // mutually exclusive by construction.
  always_comb begin
    w_exp   = in_data[30:23];
    w_man   = in_data[22:0];
    w_flags = {in_uof,
               (w_exp == 8'hFF) && (w_man != '0),
               (w_exp == 8'hFF) && (w_man == '0),
               (w_exp == 8'h00) && (w_man != '0),
               (w_exp == 8'h00) && (w_man == '0)};
  end

  // Storage array; contents are never reset, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {w_flags, in_data};
    end
  end

  // Pointers and occupancy. A push while full is refused even if a pop
  // happens in the same cycle, which keeps in_ready a pure function of state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating under/overflow event counter. A clear in the same cycle as a
  // counted push leaves the counter at 1 so that event is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_uofCnt <= '0;
    end else if (clr_cnt) begin
      r_uofCnt <= (w_push && in_uof) ? CNT_W'(1) : '0;
    end else if (w_push && in_uof && (r_uofCnt != '1)) begin
      r_uofCnt <= r_uofCnt + CNT_W'(1);
    end
  end

  // Sticky drop indicator; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dropErr <= 1'b0;
    end else if (in_valid && w_full) begin
      r_dropErr <= 1'b1;
    end
  end

  // Show-ahead head entry, forced to zero while empty so stale memory never
  // leaks onto the output.
  always_comb begin
    w_head    = w_empty ? '0 : r_mem[r_rdPtr];
    out_data  = w_head[31:0];
    out_flags = w_head[36:32];
    in_ready  = !w_full;
    out_valid = !w_empty;
    count     = r_count;
    uof_cnt   = r_uofCnt;
    drop_err  = r_dropErr;
  end

endmodule

// File: tb/tb_fp_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_fp_result_fifo
//
// Bench for fp_result_fifo. A queue-based reference model tracks the stored
// words, the event counter and the drop flag; every cycle the DUT outputs
// are compared against it, and directed scenarios add fixed-value checks.
// The counter is built narrow here so saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_fp_result_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int UMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_uof;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [4:0]       out_flags;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] uof_cnt;
  logic             clr_cnt;
  logic             drop_err;

  int checkCount = 0;
  int errorCount = 0;

  logic [32:0] modelQ [$];
  int          modelUof;
  logic        modelDrop;

  fp_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_uof    (in_uof),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .count     (count),
    .uof_cnt   (uof_cnt),
    .clr_cnt   (clr_cnt),
    .drop_err  (drop_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and reports it
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference classification from the FP32 field rules, returning
  // {uof, nan, inf, denorm, zero}
  function automatic logic [4:0] classify(input logic [32:0] e);
    int unsigned word;
    int unsigned ex;
    int unsigned man;
    logic [4:0]  f;
    word = e[31:0];
    ex   = (word >> 23) % 256;
    man  = word % (1 << 23);
    f    = 5'd0;
    f[4] = e[32];
    if (ex == 255) begin
      if (man == 0) f[2] = 1'b1; else f[3] = 1'b1;
    end else if (ex == 0) begin
      if (man == 0) f[0] = 1'b1; else f[1] = 1'b1;
    end
    return f;
  endfunction

  // Compare all outputs to the model, then advance DUT and model one edge
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic u,
                               input logic r, input logic c, input logic rst);
    logic [32:0] head;
    int          sz;
    bit          acc;
    in_valid  = v;
    in_data   = d;
    in_uof    = u;
    out_ready = r;
    clr_cnt   = c;
    rst_n     = ~rst;
    @(negedge clk);
    sz   = modelQ.size();
    head = (sz > 0) ? modelQ[0] : 33'd0;
    checkOutput("in_ready",  64'(in_ready),  64'(sz < DEPTH));
    checkOutput("out_valid", 64'(out_valid), 64'(sz > 0));
    checkOutput("out_data",  64'(out_data),  64'(head[31:0]));
    checkOutput("out_flags", 64'(out_flags), (sz > 0) ? 64'(classify(head)) : 64'd0);
    checkOutput("count",     64'(count),     64'(sz));
    checkOutput("uof_cnt",   64'(uof_cnt),   64'(modelUof));
    checkOutput("drop_err",  64'(drop_err),  64'(modelDrop));
    if (rst) begin
      modelQ.delete();
      modelUof  = 0;
      modelDrop = 1'b0;
    end else begin
      acc = v && (sz < DEPTH);
      if (v && sz == DEPTH) modelDrop = 1'b1;
      if (r && sz > 0) void'(modelQ.pop_front());
      if (acc) modelQ.push_back({u, d});
      if (c) modelUof = (acc && u) ? 1 : 0;
      else if (acc && u && modelUof < UMAX) modelUof++;
    end
    @(posedge clk);
    #1;
  endtask

  // Random FP32 word biased toward the special classes
  function automatic logic [31:0] genData();
    logic        s;
    logic [7:0]  ex;
    logic [22:0] man;
    int          sel;
    s   = 1'($urandom);
    sel = $urandom_range(0, 5);
    man = 23'($urandom);
    ex  = 8'($urandom);
    case (sel)
      0: begin ex = 8'h00; man = 23'd0; end
      1: begin ex = 8'h00; if (man == 0) man = 23'd1; end
      2: begin ex = 8'hFF; man = 23'd0; end
      3: begin ex = 8'hFF; if (man == 0) man = 23'd5; end
      default: ;
    endcase
    return {s, ex, man};
  endfunction

  task automatic doReset();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_uof = 1'b0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    modelUof = 0; modelDrop = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic push and classification
    doReset();
    applyStimulus(1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("tp1_count", 64'(count), 64'd2);
    checkOutput("tp1_data", 64'(out_data), 64'h3F800000);
    checkOutput("tp1_flags", 64'(out_flags), 64'b00000);
    checkOutput("tp1_uof", 64'(uof_cnt), 64'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("tp2_data", 64'(out_data), 64'h7F800000);
    checkOutput("tp2_flags", 64'(out_flags), 64'b10100);
    checkOutput("tp2_count", 64'(count), 64'd1);
    applyStimulus(1'b1, 32'h7FC00001, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("tp2_nan", 64'(out_flags), 64'b01000);
    applyStimulus(1'b1, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("tp2_denorm", 64'(out_flags), 64'b00010);
    applyStimulus(1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("tp2_zero", 64'(out_flags), 64'b00001);

    // Overfill by one, then drain in order
    doReset();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 8) checkOutput("full_ready", 64'(in_ready), 64'd0);
    end
    checkOutput("full_drop", 64'(drop_err), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain_order", 64'(out_data), 64'(i));
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("drain_empty", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_nounder", 64'(count), 64'd0);

    // Full plus pop: the push in that cycle is refused
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAAAA, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("fullpop_count", 64'(count), 64'd7);

    // Steady stream, one-cycle delay, pointers wrap
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'(200 + i), 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("stream_count", 64'(count), 64'd1);
      checkOutput("stream_data", 64'(out_data), 64'(200 + i));
    end
    checkOutput("stream_drop", 64'(drop_err), 64'd0);

    // Counter saturation and clear interplay
    doReset();
    for (int i = 0; i < UMAX - 1; i++) applyStimulus(1'b1, genData(), 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("uof_near", 64'(uof_cnt), 64'(UMAX - 1));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, genData(), 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("uof_sat", 64'(uof_cnt), 64'(UMAX));
    applyStimulus(1'b1, genData(), 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("uof_clrpush", 64'(uof_cnt), 64'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("uof_clr", 64'(uof_cnt), 64'd0);

    // Reset with entries stored
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'(300 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    doReset();
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_uof", 64'(uof_cnt), 64'd0);
    applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_head", 64'(out_data), 64'h12345678);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), genData(), 1'($urandom),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
